// File: rtl/mul_seq_pkg.sv
// Package shared by the sequential multiplier slice.
//   mul_state_t : control state of the iterative multiplier
//   MUL_W       : default operand / result width
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_W = 64;

endpackage

// File: rtl/mul_seq_64_or_n.sv
// OR_N: wide OR-reduction gate.
//   data : GATE_WIDTH-bit input vector
//   any  : 1 when at least one bit of data is set
module OR_N #(
  parameter int GATE_WIDTH = 64
) (
  input  logic [GATE_WIDTH-1:0] data,
  output logic                  any
);

  assign any = |data;

endmodule

// File: rtl/mul_seq_64.sv
// mul_seq_64: iterative shift-add unsigned WIDTH x WIDTH multiplier.
// One partial product per clock. MUL returns the low half of the
// 2*WIDTH product and UMULH returns the high half.
//
// Ports:
//   clk_i      rising-edge clock
//   reset_n_i  synchronous active-low reset
//   start_i    request; a_i, b_i, hi_sel_i are captured when accepted
//   a_i, b_i   multiplicand / multiplier
//   hi_sel_i   0 = low product half, 1 = high product half
//   ack_i      consumer has taken the result
//   busy_o     iteration in progress
//   done_o     result_o valid, held stable until acknowledged
//   result_o   selected product half (last value kept outside DONE)
//
// Build option:
//   MUL_SEQ_EARLY_TERM_EN - finish as soon as the remaining multiplier
//   bits are all zero instead of always running WIDTH iterations.
module mul_seq_64
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_sel_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int PW = 2 * WIDTH;

  mul_state_t       state_reg, state_next;
  logic [PW-1:0]    mcand_reg, mcand_next;
  logic [PW-1:0]    prod_reg, prod_next;
  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hi_sel_reg, hi_sel_next;
  logic             mplier_nz;

  function automatic logic [WIDTH-1:0] pick_half(input logic [PW-1:0] p, input logic hi);
    return hi ? p[PW-1:WIDTH] : p[WIDTH-1:0];
  endfunction

`ifdef MUL_SEQ_EARLY_TERM_EN
  OR_N #(
    .GATE_WIDTH(WIDTH)
  ) u_mplier_or (
    .data(mplier_reg),
    .any (mplier_nz)
  );
`else
  // Without early termination the loop never looks at the remaining bits.
  assign mplier_nz = 1'b1;
`endif

  // Partial-product accumulation for the current multiplier LSB.
  assign sum = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    prod_next   = prod_reg;
    cnt_next    = cnt_reg;
    hi_sel_next = hi_sel_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          mcand_next  = {{WIDTH{1'b0}}, a_i};
          mplier_next = b_i;
          prod_next   = '0;
          cnt_next    = '0;
          hi_sel_next = hi_sel_i;
          state_next  = RUN;
        end
      end

      RUN: begin
        if (!mplier_nz) begin
          // No set bits left: the accumulated product is already final.
          state_next  = DONE;
          result_next = pick_half(prod_reg, hi_sel_reg);
        end else begin
          prod_next   = sum;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          cnt_next    = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_next  = DONE;
            // Capture from the final sum so result_o is valid with done_o.
            result_next = pick_half(sum, hi_sel_reg);
          end
        end
      end

      DONE: begin
        if (ack_i) begin
          if (start_i) begin
            // Back-to-back request: skip IDLE.
            mcand_next  = {{WIDTH{1'b0}}, a_i};
            mplier_next = b_i;
            prod_next   = '0;
            cnt_next    = '0;
            hi_sel_next = hi_sel_i;
            state_next  = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      hi_sel_reg <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      prod_reg   <= prod_next;
      cnt_reg    <= cnt_next;
      hi_sel_reg <= hi_sel_next;
      result_reg <= result_next;
    end
  end

  assign busy_o   = (state_reg == RUN);
  assign done_o   = (state_reg == DONE);
  assign result_o = result_reg;

endmodule

// File: tb/tb_mul_seq_64.sv
module tb_mul_seq_64;

  localparam int W = 64;
`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         hi_sel;
  logic         ack;
  logic         busy;
  logic         done;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  mul_seq_64 dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .start_i  (start),
    .a_i      (a),
    .b_i      (b),
    .hi_sel_i (hi_sel),
    .ack_i    (ack),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
    logic [63:0] xa;
    logic [63:0] xb;
    bit          xh;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   pending = 1'b0;
  int   pdly    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain 128-bit product, pick requested half.
  function automatic logic [63:0] ref_res(input logic [63:0] x, input logic [63:0] y, input bit h);
    logic [127:0] p;
    p = 128'(x) * 128'(y);
    return h ? p[127:64] : p[63:0];
  endfunction

  // Reference latency in edges from acceptance to done.
  function automatic int ref_lat(input logic [63:0] y);
    int m;
    m = -1;
    for (int i = 0; i < 64; i++) if (y[i]) m = i;
    if (!EARLY) return 64;
    if (m < 0) return 1;
    return (m + 2 > 64) ? 64 : m + 2;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] xa, input logic [63:0] xb, input bit xh, input bit push);
    exp_t e;
    a = xa; b = xb; hi_sel = xh; start = 1'b1;
    if (push) begin
      e.res = ref_res(xa, xb, xh);
      e.lat = ref_lat(xb);
      e.acc = cyc + 1;
      e.xa = xa; e.xb = xb; e.xh = xh;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int lat, input bit glitch);
    int busy_cnt;
    int k;
    busy_cnt = 0;
    k = 0;
    while (!done && k < 300) begin
      if (busy) busy_cnt++;
      if (glitch && k == 19) begin
        start = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; hi_sel = ~hi_sel;
      end else if (glitch && k == 20) begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    if (k >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done_o within 300 cycles, expected after %0d", lat);
    end else begin
      check("busy_cycles", 64'(busy_cnt), 64'(lat));
    end
  endtask

  // Acknowledge the previous result (after its ack delay), optionally
  // issuing the next request on the same edge, then run it to done.
  task automatic run_txn(input logic [63:0] xa, input logic [63:0] xb, input bit xh,
                         input int dly, input bit chain, input bit glitch);
    if (pending) begin
      repeat (pdly) tick();
      ack = 1'b1;
      if (chain) issue(xa, xb, xh, 1'b1);
      tick();
      ack = 1'b0;
      start = 1'b0;
    end
    if (!(pending && chain)) begin
      issue(xa, xb, xh, 1'b1);
      tick();
      start = 1'b0;
    end
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    wait_done(ref_lat(xb), glitch);
    pending = 1'b1;
    pdly = dly;
  endtask

  // Monitor: pops the scoreboard on each new done_o, then checks the
  // result stays put for as long as done_o is held.
  initial begin
    exp_t e;
    bit   prev;
    bit   have;
    prev = 1'b0;
    have = 1'b0;
    forever begin
      tick();
      if (done && !prev) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          have = 1'b0;
          $display("FAIL unexpected_done: result %h with no request outstanding", result);
        end else begin
          e = sb.pop_front();
          have = 1'b1;
          check("result", result, e.res);
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          $display("txn a=%h b=%h hi=%0d result=%h expected=%h lat=%0d", e.xa, e.xb, e.xh,
                   result, e.res, cyc - e.acc);
        end
      end else if (done && have) begin
        check("result_hold", result, e.res);
      end
      prev = done;
    end
  end

  initial begin
    logic [63:0] ra, rb;
    bit          saw_done;
    reset_n = 1'b0; start = 1'b0; ack = 1'b0; a = '0; b = '0; hi_sel = 1'b0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    reset_n = 1'b1;
    tick();

    run_txn(64'd3, 64'd5, 1'b0, 5, 1'b0, 1'b0);
    run_txn('1, '1, 1'b1, 0, 1'b0, 1'b0);
    run_txn('1, '1, 1'b0, 1, 1'b0, 1'b0);
    run_txn(64'd7, 64'd6, 1'b0, 2, 1'b1, 1'b0);
    run_txn({$urandom, $urandom}, 64'h8000_0000_0000_0001, 1'b1, 0, 1'b0, 1'b1);
    run_txn(64'd5, 64'd0, 1'b0, 1, 1'b0, 1'b0);
    run_txn(64'd9, 64'd1, 1'b0, 0, 1'b1, 1'b0);
    run_txn(64'd9, 64'h8000_0000_0000_0000, 1'b1, 0, 1'b0, 1'b0);
    run_txn(64'd0, {$urandom, $urandom}, 1'b1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = rb >> $urandom_range(0, 63);
        1: if ($urandom_range(0, 7) == 0) rb = '0;
        default: ;
      endcase
      run_txn(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'b0);
    end
    run_txn(64'd3, 64'd5, 1'b0, 0, 1'b0, 1'b0);

    // Release the last result, then abort a fresh operation with reset.
    repeat (pdly) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    pending = 1'b0;
    issue({$urandom, $urandom}, {$urandom, $urandom} | 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    repeat (29) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_done", 64'(done), 64'd0);
    check("midrun_reset_result", result, 64'd0);
    saw_done = 1'b0;
    repeat (80) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_reset", 64'(saw_done), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
